// File: rtl/tdc_scan_master.sv
// rtl/tdc_scan_master.sv - serial capture/shift/update initiator for UDR chains
`timescale 1ns/1ps

module tdc_scan_master #(
    parameter int DR_LENGTH = 16,
    parameter int CNT_W     = $clog2(DR_LENGTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 upd_en,
    input  logic [DR_LENGTH-1:0] wdata,
    output logic                 scan_capture,
    output logic                 scan_shift,
    output logic                 scan_update,
    output logic                 scan_sdo,
    input  logic                 scan_sdi,
    output logic                 busy,
    output logic                 done,
    output logic [DR_LENGTH-1:0] rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SHIFT   = 2'd2,
        UPDATE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DR_LENGTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DR_LENGTH);

    state_t               state_q, state_d;
    logic [DR_LENGTH-1:0] wsh_q, wsh_d;
    logic [DR_LENGTH-1:0] rd_q, rd_d;
    logic [DR_LENGTH-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 upd_q, upd_d;
    logic                 capture_q, capture_d;
    logic                 shift_q, shift_d;
    logic                 update_q, update_d;
    logic                 sdo_q, sdo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    always_comb begin
        state_d = state_q;
        wsh_d   = wsh_q;
        rd_d    = rd_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        upd_d   = upd_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    wsh_d   = wdata;
                    upd_d   = upd_en;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                wsh_d = wsh_q >> 1;
                rd_d  = {scan_sdi, rd_q[DR_LENGTH-1:1]};
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (cnt_q == CNT_LAST) begin
                    if (upd_q) begin
                        state_d = UPDATE;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            UPDATE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so every pin comes straight off a flop.
        capture_d = (state_d == CAPTURE);
        shift_d   = (state_d == SHIFT);
        update_d  = (state_d == UPDATE);
        busy_d    = (state_d != IDLE);
        sdo_d     = (state_d == SHIFT) ? wsh_d[0] : sdo_q;
        if (done_d) begin
            rdata_d = rd_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wsh_q     <= '0;
            rd_q      <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            upd_q     <= 1'b0;
            capture_q <= 1'b0;
            shift_q   <= 1'b0;
            update_q  <= 1'b0;
            sdo_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wsh_q     <= wsh_d;
            rd_q      <= rd_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            upd_q     <= upd_d;
            capture_q <= capture_d;
            shift_q   <= shift_d;
            update_q  <= update_d;
            sdo_q     <= sdo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign scan_capture = capture_q;
    assign scan_shift   = shift_q;
    assign scan_update  = update_q;
    assign scan_sdo     = sdo_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign rdata        = rdata_q;

endmodule

// File: tb/tb_tdc_scan_master.sv
// tb/tb_tdc_scan_master.sv - randomized scoreboard bench for tdc_scan_master with a UDR model
`timescale 1ns/1ps

module tb_tdc_scan_master;

    localparam int DR = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          upd_en = 1'b0;
    logic [DR-1:0] wdata = '0;
    logic          scan_capture, scan_shift, scan_update, scan_sdo, scan_sdi;
    logic          busy, done;
    logic [DR-1:0] rdata;

    logic          udr_rst_n = 1'b0;
    logic          udr_load = 1'b0;
    logic [DR-1:0] udr_val = '0;
    logic [DR-1:0] udr_shadow, udr_pout;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [DR-1:0] wdata;
        logic          upd;
        logic [DR-1:0] rdata;
        logic [DR-1:0] pout;
        int            t0;
    } exp_t;

    exp_t          sb_q[$];
    logic [DR-1:0] udr_ref;

    tdc_scan_master #(.DR_LENGTH(DR)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .upd_en       (upd_en),
        .wdata        (wdata),
        .scan_capture (scan_capture),
        .scan_shift   (scan_shift),
        .scan_update  (scan_update),
        .scan_sdo     (scan_sdo),
        .scan_sdi     (scan_sdi),
        .busy         (busy),
        .done         (done),
        .rdata        (rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // UDR: shadow shift register plus parallel output, reset_value = 0
    always @(posedge clk or negedge udr_rst_n) begin
        if (!udr_rst_n) begin
            udr_shadow <= '0;
            udr_pout   <= '0;
        end else begin
            if (scan_capture)     udr_shadow <= udr_pout;
            else if (scan_shift)  udr_shadow <= {scan_sdo, udr_shadow[DR-1:1]};
            if (scan_update)      udr_pout   <= udr_shadow;
            else if (udr_load)    udr_pout   <= udr_val;
        end
    end
    assign scan_sdi = udr_shadow[0];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: accumulates strobe history per access and scores it on each done pulse.
    initial begin : monitor
        int            cap_n, shf_n, upd_n;
        bit            order_ok, prev_done;
        logic [DR-1:0] sdo_word;
        exp_t          e;
        cap_n = 0; shf_n = 0; upd_n = 0; order_ok = 1; prev_done = 0; sdo_word = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cap_n = 0; shf_n = 0; upd_n = 0; order_ok = 1; prev_done = 0; sdo_word = '0;
                continue;
            end
            if ((int'(scan_capture) + int'(scan_shift) + int'(scan_update)) > 1) order_ok = 0;
            if (scan_capture) begin
                if (cap_n != 0 || shf_n != 0 || upd_n != 0) order_ok = 0;
                cap_n++;
            end
            if (scan_shift) begin
                if (cap_n != 1 || upd_n != 0) order_ok = 0;
                if (shf_n < DR) sdo_word[shf_n] = scan_sdo;
                shf_n++;
            end
            if (scan_update) begin
                if (shf_n != DR) order_ok = 0;
                upd_n++;
            end
            if (done) begin
                check("pending_on_done", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("rdata", 64'(rdata), 64'(e.rdata));
                    check("done_latency", 64'(cyc - e.t0), e.upd ? 64'(DR + 3) : 64'(DR + 2));
                    check("busy_in_done", 64'(busy), 64'd0);
                    check("done_single", 64'(prev_done), 64'd0);
                    check("capture_count", 64'(cap_n), 64'd1);
                    check("shift_count", 64'(shf_n), 64'(DR));
                    check("update_count", 64'(upd_n), 64'(e.upd));
                    check("strobe_order", 64'(order_ok), 64'd1);
                    check("sdo_stream", 64'(sdo_word), 64'(e.wdata));
                    check("udr_parallel", 64'(udr_pout), 64'(e.pout));
                end
                cap_n = 0; shf_n = 0; upd_n = 0; order_ok = 1; sdo_word = '0;
            end
            prev_done = done;
        end
    end

    // Reference model: a read returns what the UDR holds; a write replaces it afterwards.
    task automatic start_only(input logic [DR-1:0] wd, input logic upd);
        exp_t e;
        e.wdata = wd;
        e.upd   = upd;
        e.rdata = udr_ref;
        e.pout  = upd ? wd : udr_ref;
        e.t0    = cyc;
        sb_q.push_back(e);
        udr_ref = e.pout;
        start  = 1'b1;
        wdata  = wd;
        upd_en = upd;
        @(posedge clk);
        #1;
        start  = 1'b0;
        wdata  = DR'($urandom);
        upd_en = 1'($urandom);
    endtask

    task automatic wait_done();
        bit found;
        found = 0;
        for (int i = 0; i < 4 * DR; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1;
                break;
            end
        end
        check("done_timeout", 64'(found), 64'd1);
    endtask

    task automatic do_access(input logic [DR-1:0] wd, input logic upd, input bit poke,
                             input logic [DR-1:0] poke_wd);
        start_only(wd, upd);
        if (poke) begin
            repeat ($urandom_range(1, DR - 2)) @(negedge clk);
            start  = 1'b1;
            wdata  = poke_wd;
            upd_en = ~upd;
            @(posedge clk);
            #1;
            start  = 1'b0;
        end
        wait_done();
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 64'({scan_capture, scan_shift, scan_update, scan_sdo, busy, done}), 64'd0);
        check({name, "_rdata"}, 64'(rdata), 64'd0);
    endtask

    initial begin : stim
        logic [DR-1:0] saved;
        udr_ref = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        rst_n     = 1'b1;
        udr_rst_n = 1'b1;
        @(negedge clk);

        do_access(16'hA5C3, 1'b1, 1'b0, '0);
        do_access(16'h1234, 1'b1, 1'b0, '0);
        do_access(16'hFFFF, 1'b0, 1'b0, '0);
        do_access(16'h3C96, 1'b1, 1'b1, 16'h0F0F);
        repeat (4) @(negedge clk);

        // Abort a write during its 8th shift cycle; the UDR must keep its prior word.
        saved = udr_ref;
        start_only(16'h5555, 1'b1);
        repeat (9) @(negedge clk);
        check("rst_in_shift", 64'(scan_shift), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        sb_q.delete();
        udr_ref = saved;
        repeat (3) @(negedge clk);
        check("abort_no_update", 64'(udr_pout), 64'(saved));
        check_reset_outputs("held_reset");
        rst_n = 1'b1;
        @(negedge clk);
        do_access(16'h6E01, 1'b1, 1'b0, '0);

        @(negedge clk);
        udr_load = 1'b1;
        udr_val  = 16'h00C0;
        @(posedge clk);
        #1;
        udr_load = 1'b0;
        udr_ref  = 16'h00C0;
        @(negedge clk);
        do_access(DR'($urandom), 1'b1, 1'b0, '0);

        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            if (gap != 0 && $urandom_range(0, 3) == 0) begin
                udr_load = 1'b1;
                udr_val  = DR'($urandom);
                @(posedge clk);
                #1;
                udr_load = 1'b0;
                udr_ref  = udr_val;
                @(negedge clk);
            end
            do_access(DR'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0), DR'($urandom));
        end

        repeat (6) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
